fmul_share: RTL
===============

FMUL_SHARE -- requirements
Module: fmul_share

Interface
REQ-001 SHALL have parameter LAT, default 2, giving the pipeline depth from operand capture to result-write (legal 1..4).
REQ-002 SHALL have parameter DEPTH, default 4, giving the response FIFO depth per requester and the initial credit count (legal 2..8).
REQ-003 SHALL have parameter TAG_W, default 4, giving the width of the requester-supplied tag.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 reqN_valid  input  1  requester N (N=0,1) presents an operand pair.
REQ-007 reqN_ready  output  1  grant to requester N this cycle.
REQ-008 reqN_x1, reqN_x2  input  32  IEEE-754 single operands.
REQ-009 reqN_tag  input  TAG_W  opaque tag, returned with the result.
REQ-010 rspN_valid  output  1  result available for requester N.
REQ-011 rspN_ready  input  1  requester N accepts its result.
REQ-012 rspN_y  output  32  product; rspN_ovf  output  1  overflow flag; rspN_tag  output  TAG_W  returned tag.
REQ-013 busy  output  1  high while any operation is in the pipeline or any response FIFO is non-empty.

Function
REQ-014 SHALL instantiate exactly one fmul and share it between the two requesters; no operand SHALL bypass it.
REQ-015 Request handshake SHALL occur when reqN_valid && reqN_ready; the response handshake SHALL occur when rspN_valid && rspN_ready.
REQ-016 At most one reqN_ready SHALL be high per cycle; reqN_ready SHALL depend only on state, reqN_valid and the other request's valid, never on the operands.
REQ-017 Requester N SHALL be eligible only while reqN_valid=1 and creditN>0.
REQ-018 Arbitration SHALL be round-robin: the prio bit selects which eligible requester wins when both are eligible; after any grant, prio SHALL point to the non-granted requester; a sole eligible requester SHALL win regardless of prio.
REQ-019 creditN SHALL decrement on a request handshake for N and increment on a response handshake for N; both in one cycle SHALL leave it unchanged; creditN SHALL never exceed DEPTH or go below 0.
REQ-020 A grant in cycle t SHALL capture x1, x2, tag and requester id into stage 1 at the end of cycle t; fmul SHALL be evaluated on the stage-1 registers; the result SHALL advance one stage per cycle without stalls.
REQ-021 The stage-LAT result (y, ovf, tag) SHALL be pushed into FIFO[id] at the end of cycle t+LAT; rspN_valid SHALL rise in cycle t+LAT+1 when that FIFO was empty.
REQ-022 The pipeline SHALL never stall; credits SHALL guarantee FIFO space, so a push into a full FIFO SHALL be unreachable.
REQ-023 Each FIFO SHALL be first-in first-out with wrap-around pointers; a simultaneous push and pop SHALL be legal at any occupancy, including full and empty.
REQ-024 rspN_y, rspN_ovf and rspN_tag SHALL hold the FIFO head and remain stable while rspN_valid=1 and rspN_ready=0.
REQ-025 Results per requester SHALL return in issue order; results for different requesters are independent.
REQ-026 Sustained throughput SHALL be one grant per cycle while any requester is eligible.
REQ-027 rspN_y and rspN_ovf SHALL be bit-identical to fmul's combinational output for the captured operands.

Reset
REQ-028 While rst=1: reqN_ready=0, rspN_valid=0, busy=0, all pipeline valid bits cleared, FIFOs empty, creditN=DEPTH, prio=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight and buffered results; no rspN_valid SHALL appear from pre-reset requests.
REQ-030 Data and tag registers need not be reset.

Verification
REQ-031 Single op, LAT=2: req0 x1=0x7F000000, x2=0x7F000000, tag=3, granted in cycle t -> rsp0_valid in cycle t+3, rsp0_y=0x7F800000, rsp0_ovf=1, rsp0_tag=3.
REQ-032 Underflow: req1 x1=0x00800000, x2=0x00800000 -> rsp1_y=0x00000000, rsp1_ovf=0.
REQ-033 Contention: both valid continuously, prio=0 after reset -> grants alternate 0,1,0,1; each rspN carries its own tags in order.
REQ-034 Backpressure: rsp0_ready=0, req0 valid continuously, DEPTH=4 -> exactly 4 grants to req0, then req0_ready=0; while req1 continues at full rate; raising rsp0_ready drains 4 results in order and grants resume.
REQ-035 Reset mid-flight: 2 ops in the pipeline, rst pulsed 1 cycle -> no responses, busy=0, credit0=credit1=DEPTH afterwards.
REQ-036 FIFO boundary: simultaneous push and pop at full and at empty occupancy -> no loss, no duplication, order preserved.

Source files
------------

// File: rtl/fmul_share.sv
`default_nettype none
// ============================================================================
// Module   : fmul_share (plus its single-precision multiplier, fmul)
// Brief    : Two requesters share one pipelined FP32 multiplier. Grants are
//            round-robin and credit-gated, and each requester has its own
//            response FIFO.
// Revision : 1.0 - initial release
// ============================================================================

module fmul (
  input  logic [31:0] i_x1,
  input  logic [31:0] i_x2,
  output logic [31:0] o_y,
  output logic        o_ovf
);
  logic              w_sign;
  logic [7:0]        w_ea;
  logic [7:0]        w_eb;
  logic [47:0]       w_prod;
  logic signed [9:0] w_exp;
  logic [22:0]       w_mant;
  logic              w_unused;

  assign w_sign = i_x1[31] ^ i_x2[31];
  assign w_ea   = i_x1[30:23];
  assign w_eb   = i_x2[30:23];
  assign w_prod = {24'b0, 1'b1, i_x1[22:0]} * {24'b0, 1'b1, i_x2[22:0]};
  assign w_exp  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb})
                + $signed({9'b0, w_prod[47]}) - 10'sd127;
  assign w_mant = w_prod[47] ? w_prod[46:24] : w_prod[45:23];
  assign w_unused = &{1'b0, w_prod[22:0]};

  // Mantissa is truncated. Subnormal inputs and results flush to zero, and an
  // Inf/NaN operand yields Inf without raising overflow.
  always_comb begin
    o_y   = '0;
    o_ovf = 1'b0;
    if (w_ea == 8'hFF || w_eb == 8'hFF) begin
      o_y = {w_sign, 8'hFF, 23'b0};
    end else if (w_ea == 8'h00 || w_eb == 8'h00) begin
      o_y = {w_sign, 31'b0};
    end else if (w_exp >= 10'sd255) begin
      o_y   = {w_sign, 8'hFF, 23'b0};
      o_ovf = 1'b1;
    end else if (w_exp <= 10'sd0) begin
      o_y = {w_sign, 31'b0};
    end else begin
      o_y = {w_sign, w_exp[7:0], w_mant};
    end
  end
endmodule

module fmul_share #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_x1,
  input  logic [31:0]      req0_x2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_x1,
  input  logic [31:0]      req1_x2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_y,
  output logic             rsp0_ovf,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_y,
  output logic             rsp1_ovf,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             busy
);
  localparam int c_pw = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int c_cw = $clog2(DEPTH + 1);

  logic [1:0]          w_req_v;
  logic [1:0]          w_elig;
  logic [1:0]          w_gnt;
  logic [1:0]          w_push;
  logic [1:0]          w_pop;
  logic [1:0]          w_rsp_rdy;
  logic [1:0]          w_hv;
  logic [1:0]          w_ho;
  logic [31:0]         w_hy [2];
  logic [TAG_W-1:0]    w_ht [2];
  logic                r_prio;

  logic [LAT:1]        r_v;
  logic [LAT:1]        r_id;
  logic [TAG_W-1:0]    r_tag [1:LAT];
  logic [31:0]         r_x1;
  logic [31:0]         r_x2;
  logic [31:0]         w_fy;
  logic                w_fovf;
  logic [LAT:1][31:0]  w_sy;
  logic [LAT:1]        w_sovf;

  assign w_req_v   = {req1_valid, req0_valid};
  assign w_rsp_rdy = {rsp1_ready, rsp0_ready};

  // Round-robin: r_prio names the requester that wins a tie.
  assign w_gnt[0] = !rst && w_elig[0] && (!w_elig[1] || !r_prio);
  assign w_gnt[1] = !rst && w_elig[1] && (!w_elig[0] ||  r_prio);
  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];

  always_ff @(posedge clk) begin
    if (rst)           r_prio <= 1'b0;
    else if (w_gnt[0]) r_prio <= 1'b1;
    else if (w_gnt[1]) r_prio <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
    end else begin
      r_v[1] <= |w_gnt;
      for (int k = 2; k <= LAT; k++) r_v[k] <= r_v[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (|w_gnt) begin
      r_x1     <= w_gnt[1] ? req1_x1  : req0_x1;
      r_x2     <= w_gnt[1] ? req1_x2  : req0_x2;
      r_tag[1] <= w_gnt[1] ? req1_tag : req0_tag;
      r_id[1]  <= w_gnt[1];
    end
    for (int k = 2; k <= LAT; k++) begin
      r_tag[k] <= r_tag[k-1];
      r_id[k]  <= r_id[k-1];
    end
  end

  fmul u_fmul (
    .i_x1  (r_x1),
    .i_x2  (r_x2),
    .o_y   (w_fy),
    .o_ovf (w_fovf)
  );

  assign w_sy[1]   = w_fy;
  assign w_sovf[1] = w_fovf;

  for (genvar k = 2; k <= LAT; k++) begin : g_stage
    logic [31:0] r_y;
    logic        r_ovf;
    always_ff @(posedge clk) begin
      r_y   <= w_sy[k-1];
      r_ovf <= w_sovf[k-1];
    end
    assign w_sy[k]   = r_y;
    assign w_sovf[k] = r_ovf;
  end

  for (genvar n = 0; n < 2; n++) begin : g_req
    logic [c_cw-1:0]  r_cred;
    logic [c_cw-1:0]  r_cnt;
    logic [c_pw-1:0]  r_wp;
    logic [c_pw-1:0]  r_rp;
    logic [31:0]      r_my [DEPTH];
    logic             r_mo [DEPTH];
    logic [TAG_W-1:0] r_mt [DEPTH];

    assign w_elig[n] = w_req_v[n] && (r_cred != '0);
    assign w_push[n] = r_v[LAT] && (r_id[LAT] == 1'(n));
    assign w_pop[n]  = w_hv[n] && w_rsp_rdy[n];
    assign w_hv[n]   = !rst && (r_cnt != '0);
    assign w_hy[n]   = r_my[r_rp];
    assign w_ho[n]   = r_mo[r_rp];
    assign w_ht[n]   = r_mt[r_rp];

    // Credits count FIFO slots not yet claimed, so a push never finds it full.
    always_ff @(posedge clk) begin
      if (rst)                       r_cred <= c_cw'(DEPTH);
      else if (w_gnt[n] && !w_pop[n]) r_cred <= r_cred - c_cw'(1);
      else if (!w_gnt[n] && w_pop[n]) r_cred <= r_cred + c_cw'(1);
    end

    always_ff @(posedge clk) begin
      if (w_push[n]) begin
        r_my[r_wp] <= w_sy[LAT];
        r_mo[r_wp] <= w_sovf[LAT];
        r_mt[r_wp] <= r_tag[LAT];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push[n]) r_wp <= (r_wp == c_pw'(DEPTH - 1)) ? '0 : r_wp + c_pw'(1);
        if (w_pop[n])  r_rp <= (r_rp == c_pw'(DEPTH - 1)) ? '0 : r_rp + c_pw'(1);
        if (w_push[n] && !w_pop[n])      r_cnt <= r_cnt + c_cw'(1);
        else if (!w_push[n] && w_pop[n]) r_cnt <= r_cnt - c_cw'(1);
      end
    end
  end

  assign rsp0_valid = w_hv[0];
  assign rsp0_y     = w_hy[0];
  assign rsp0_ovf   = w_ho[0];
  assign rsp0_tag   = w_ht[0];
  assign rsp1_valid = w_hv[1];
  assign rsp1_y     = w_hy[1];
  assign rsp1_ovf   = w_ho[1];
  assign rsp1_tag   = w_ht[1];

  assign busy = !rst && ((|r_v) || (|w_hv));
endmodule
`default_nettype wire
